fdiv_meas_ctrl: RTL and testbench

FDIV_MEAS_CTRL -- requirements
Module: fdiv_meas_ctrl

---
 rtl/fdiv_meas_ctrl.sv | 141 ++++++++++++++
 tb/tb_fdiv_meas_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_meas_ctrl.sv
// fdiv_meas_ctrl: frequency-measurement controller for an asynchronous
// divide-by-16 chain. It resets the divider, lets the synchronizer settle,
// counts synchronized rising edges of div_in over a programmable window,
// and reports the count with a one-cycle done pulse.
module fdiv_meas_ctrl #(
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             div_in,
  output logic             div_en,
  output logic             div_rstb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_DIV,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam logic [WIN_W-1:0] TMR_ONE     = WIN_W'(1);
  localparam logic [WIN_W-1:0] RST_LAST    = WIN_W'(1);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SYNC_STAGES);

  state_t                 r_state;
  state_t                 w_next;
  logic [WIN_W-1:0]       r_tmr;
  logic [WIN_W-1:0]       r_win;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_accept;
  logic                   r_div_en;
  logic                   r_div_rstb;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  logic                   w_div_en;
  logic                   w_div_rstb;
  logic                   w_busy;
  logic                   w_done;

  assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_accept = (r_state == S_IDLE) && start;

  // Synchronize div_in into the clk domain and keep the previous sample.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], div_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Next-state logic; abort wins over every normal exit of an active phase.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_RST_DIV;
      S_RST_DIV: begin
        if (abort)                  w_next = S_IDLE;
        else if (r_tmr == RST_LAST) w_next = S_SETTLE;
      end
      S_SETTLE:  begin
        if (abort)                     w_next = S_IDLE;
        else if (r_tmr == SETTLE_LAST) w_next = (r_win == '0) ? S_DONE : S_MEASURE;
      end
      S_MEASURE: begin
        if (abort)                           w_next = S_IDLE;
        else if (r_tmr == (r_win - TMR_ONE)) w_next = S_DONE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    w_busy     = (w_next != S_IDLE);
    w_done     = (w_next == S_DONE);
    w_div_en   = (w_next == S_SETTLE) || (w_next == S_MEASURE);
    w_div_rstb = (w_next != S_RST_DIV);
  end

  // State register, phase timer and registered control outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_div_en   <= 1'b0;
      r_div_rstb <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tmr      <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_tmr + TMR_ONE;
      r_div_en   <= w_div_en;
      r_div_rstb <= w_div_rstb;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Window latch and saturating edge counter; results hold until the next accepted start.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_win   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_win   <= win_len;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if ((r_state == S_MEASURE) && w_rise) begin
      if (r_count == '1) r_ovf   <= 1'b1;
      else               r_count <= r_count + CNT_W'(1);
    end
  end

  assign div_en   = r_div_en;
  assign div_rstb = r_div_rstb;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_fdiv_meas_ctrl.sv
// Bench for fdiv_meas_ctrl: two instances (default CNT_W and CNT_W=4) share
// control inputs; each drives its own behavioural divider (clk/8 and clk/4)
// that is cleared by div_rstb and advanced by div_en, like the real chain.
module tb_fdiv_meas_ctrl;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] win_len = '0;

  logic        div_in, div_en, div_rstb, busy, done, ovf;
  logic [11:0] count;
  logic        div_in4, div_en4, div_rstb4, busy4, done4, ovf4;
  logic [3:0]  count4;

  logic [2:0]  r_d8 = '0;
  logic [1:0]  r_d4 = '0;

  typedef struct {
    int lat;
    int cnt;
    int ovf;
    int cnt4;
    int ovf4;
    int en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!div_rstb)   r_d8 <= '0;
    else if (div_en) r_d8 <= r_d8 + 3'd1;
    if (!div_rstb4)   r_d4 <= '0;
    else if (div_en4) r_d4 <= r_d4 + 2'd1;
  end
  assign div_in  = r_d8[2];
  assign div_in4 = r_d4[1];

  fdiv_meas_ctrl #(.WIN_W(16), .CNT_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .win_len(win_len),
    .div_in(div_in), .div_en(div_en), .div_rstb(div_rstb), .busy(busy),
    .done(done), .count(count), .ovf(ovf)
  );

  fdiv_meas_ctrl #(.WIN_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .win_len(win_len),
    .div_in(div_in4), .div_en(div_en4), .div_rstb(div_rstb4), .busy(busy4),
    .done(done4), .count(count4), .ovf(ovf4)
  );

  // Counts negedges until done is seen; lat is the number of clk edges since start was sampled.
  task automatic wait_done(input int start_lat, input bit keep, output int lat,
                           output int en_cyc, output bit to);
    lat = start_lat;
    en_cyc = 0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (!keep) start = 1'b0;
      if (div_en) en_cyc++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rstb = 1'b0;
    #1;
    checks++; if (div_en !== 1'b0)   begin errors++; $display("FAIL reset_div_en: got %b expected 0", div_en); end
    checks++; if (div_rstb !== 1'b0) begin errors++; $display("FAIL reset_div_rstb: got %b expected 0", div_rstb); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (count !== 12'd0)   begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    #1;
    checks++; if (div_rstb !== 1'b0) begin errors++; $display("FAIL rel_div_rstb_before_edge: got %b expected 0", div_rstb); end
    @(negedge clk);
    checks++; if (div_rstb !== 1'b1) begin errors++; $display("FAIL rel_div_rstb_after_edge: got %b expected 1", div_rstb); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rel_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int lat, en; bit to; exp_t e;
    win_len = 16'd64;
    sb.push_back('{lat: 70, cnt: 8, ovf: 0, cnt4: -1, ovf4: -1, en: 67});
    start = 1'b1;
    wait_done(0, 1'b0, lat, en, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (count !== 12'(e.cnt)) begin errors++; $display("FAIL basic_count: got %0d expected %0d", count, e.cnt); end
    checks++; if (ovf !== 1'(e.ovf)) begin errors++; $display("FAIL basic_ovf: got %b expected %0d", ovf, e.ovf); end
    checks++; if (en != e.en) begin errors++; $display("FAIL basic_div_en_cycles: got %0d expected %0d", en, e.en); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_zero_len;
    int lat, en; bit to; exp_t e;
    win_len = 16'd0;
    sb.push_back('{lat: 6, cnt: 0, ovf: 0, cnt4: -1, ovf4: -1, en: 3});
    start = 1'b1;
    wait_done(0, 1'b0, lat, en, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL zero_timeout: got no done expected done"); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (count !== 12'(e.cnt)) begin errors++; $display("FAIL zero_count: got %0d expected %0d", count, e.cnt); end
    checks++; if (en != e.en) begin errors++; $display("FAIL zero_div_en_cycles: got %0d expected %0d", en, e.en); end
    checks++; if (div_en !== 1'b0) begin errors++; $display("FAIL zero_div_en_in_done: got %b expected 0", div_en); end
    @(negedge clk);
  endtask

  task automatic test_ovf;
    int lat, en; bit to; exp_t e;
    win_len = 16'd100;
    sb.push_back('{lat: 106, cnt: 13, ovf: 0, cnt4: 15, ovf4: 1, en: 103});
    start = 1'b1;
    wait_done(0, 1'b0, lat, en, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout: got no done expected done"); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL ovf_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (count !== 12'(e.cnt)) begin errors++; $display("FAIL ovf_count8: got %0d expected %0d", count, e.cnt); end
    checks++; if (ovf !== 1'(e.ovf)) begin errors++; $display("FAIL ovf_ovf8: got %b expected %0d", ovf, e.ovf); end
    if (e.cnt4 >= 0) begin
      checks++; if (count4 !== 4'(e.cnt4)) begin errors++; $display("FAIL ovf_count4: got %0d expected %0d", count4, e.cnt4); end
      checks++; if (ovf4 !== 1'(e.ovf4)) begin errors++; $display("FAIL ovf_ovf4: got %b expected %0d", ovf4, e.ovf4); end
    end
    repeat (4) @(negedge clk);
    checks++; if (count4 !== 4'd15 || ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_hold: got count=%0d ovf=%b expected 15 1", count4, ovf4); end
  endtask

  task automatic test_clear;
    int lat, en; bit to; exp_t e;
    win_len = 16'd1;
    sb.push_back('{lat: 7, cnt: 0, ovf: 0, cnt4: 0, ovf4: 0, en: 4});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (count4 !== 4'd0 || ovf4 !== 1'b0) begin errors++; $display("FAIL clear_on_start: got count=%0d ovf=%b expected 0 0", count4, ovf4); end
    checks++; if (busy !== 1'b1 || div_rstb !== 1'b0) begin errors++; $display("FAIL clear_rst_div: got busy=%b div_rstb=%b expected 1 0", busy, div_rstb); end
    wait_done(1, 1'b0, lat, en, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL clear_timeout: got no done expected done"); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL clear_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (count !== 12'(e.cnt) || count4 !== 4'(e.cnt4)) begin errors++; $display("FAIL clear_count: got %0d/%0d expected %0d/%0d", count, count4, e.cnt, e.cnt4); end
    checks++; if (en != e.en) begin errors++; $display("FAIL clear_div_en_cycles: got %0d expected %0d", en, e.en); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int seen_done;
    win_len = 16'd64;
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 15) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (div_en !== 1'b0 || div_rstb !== 1'b1) begin errors++; $display("FAIL abort_div_ctrl: got en=%b rstb=%b expected 0 1", div_en, div_rstb); end
    checks++; if (count !== 12'd1) begin errors++; $display("FAIL abort_count: got %0d expected 1", count); end
    seen_done = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || count !== 12'd1) begin errors++; $display("FAIL abort_idle: got busy=%b count=%0d expected 0 1", busy, count); end
  endtask

  task automatic test_back_to_back;
    int lat, en; bit to; exp_t e;
    win_len = 16'd64;
    sb.push_back('{lat: 70, cnt: 8, ovf: 0, cnt4: -1, ovf4: -1, en: 67});
    sb.push_back('{lat: 70, cnt: 8, ovf: 0, cnt4: -1, ovf4: -1, en: 67});
    start = 1'b1;
    wait_done(0, 1'b1, lat, en, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL b2b1_timeout: got no done expected done"); end
    checks++; if (lat != e.lat || count !== 12'(e.cnt)) begin errors++; $display("FAIL b2b1_result: got lat=%0d count=%0d expected %0d %0d", lat, count, e.lat, e.cnt); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || div_rstb !== 1'b0) begin errors++; $display("FAIL b2b_restart: got busy=%b div_rstb=%b expected 1 0", busy, div_rstb); end
    start = 1'b0;
    wait_done(1, 1'b0, lat, en, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL b2b2_timeout: got no done expected done"); end
    checks++; if (lat != e.lat || count !== 12'(e.cnt) || ovf !== 1'(e.ovf)) begin errors++; $display("FAIL b2b2_result: got lat=%0d count=%0d ovf=%b expected %0d %0d %0d", lat, count, ovf, e.lat, e.cnt, e.ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen_done;
    win_len = 16'd64;
    start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rstb = 1'b0;
    #1;
    checks++; if (div_en !== 1'b0 || div_rstb !== 1'b0) begin errors++; $display("FAIL midrst_div_ctrl: got en=%b rstb=%b expected 0 0", div_en, div_rstb); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done: got %b %b expected 0 0", busy, done); end
    checks++; if (count !== 12'd0 || ovf !== 1'b0) begin errors++; $display("FAIL midrst_count_ovf: got %0d %b expected 0 0", count, ovf); end
    @(negedge clk);
    rstb = 1'b1;
    seen_done = 0;
    repeat (100) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_ovf();
    test_clear();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
